id_issue_controller: RTL and testbench

// Decode-stage sequencer. Runs each cycle on the instruction held in IF/ID and does four jobs:
// - selects the immediate extension mode (drives the sign-extension unit's i_is_signed);
// - detects load-use hazards and inserts one bubble;
// - squashes on branch flush and latches HALT;
// - gates issue in debug single-step mode.
// It drives the PC / IF-ID write enables and the ID/EX valid/control bits.

---
 rtl/id_issue_controller.sv | 89 ++++++++
 tb/tb_id_issue_controller.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/id_issue_controller.sv
// id_issue_controller: decode-stage sequencer for immediate mode, load-use stalls, flush, halt and single-step issue
module id_issue_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W = 16,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD = {DATA_WIDTH{1'b1}}
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_instr_valid,
    input  logic [DATA_WIDTH-1:0] i_instruction,
    input  logic                  i_idex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_idex_rt,
    input  logic                  i_branch_flush,
    input  logic                  i_debug_mode,
    input  logic                  i_step,
    output logic                  o_is_signed,
    output logic                  o_advance,
    output logic                  o_idex_valid,
    output logic                  o_idex_is_signed,
    output logic                  o_halted,
    output logic [CNT_W-1:0]      o_stall_count,
    output logic [CNT_W-1:0]      o_issue_count
);
    typedef enum logic [1:0] {RUN, STEP_WAIT, STALL, HALTED} state_t;
    state_t state, state_next, mode_state;
    logic [5:0] opcode;
    logic [REG_ADDR_W-1:0] rs, rt;
    logic rt_src, hazard, go, halt_req, do_issue, do_stall, do_halt;
    assign opcode = i_instruction[DATA_WIDTH-1 -: 6];
    assign rs = i_instruction[21 +: REG_ADDR_W];
    assign rt = i_instruction[16 +: REG_ADDR_W];
    assign rt_src = opcode inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B};
    assign o_is_signed = opcode[5:2] != 4'b0011;
    assign hazard = i_instr_valid & o_idex_valid & i_idex_mem_read & (i_idex_rt != '0)
                  & ((i_idex_rt == rs) | (rt_src & (i_idex_rt == rt)));
    assign go = (state == RUN & !i_debug_mode) | (state == STEP_WAIT & i_step) | (state == STALL);
    assign halt_req = i_instr_valid & (i_instruction == HALT_WORD);
    assign mode_state = i_debug_mode ? STEP_WAIT : RUN;

    // State register; reset always lands in RUN
    always_ff @(posedge i_clk) begin
        state <= i_reset ? RUN : state_next;
    end

    // Per-cycle decision in priority order: halted, flush, no-go, halt word, hazard, issue
    always_comb begin
        state_next = state;
        o_advance = 1'b0;
        do_issue = 1'b0;
        do_stall = 1'b0;
        do_halt = 1'b0;
        if (state == HALTED) begin
            state_next = HALTED;
        end else if (i_branch_flush) begin
            o_advance = 1'b1;
            state_next = mode_state;
        end else if (!go) begin
            state_next = mode_state;
        end else if (halt_req) begin
            do_halt = 1'b1;
            state_next = HALTED;
        end else if (hazard) begin
            do_stall = 1'b1;
            state_next = STALL;
        end else begin
            o_advance = 1'b1;
            do_issue = 1'b1;
            state_next = mode_state;
        end
    end

    // ID/EX control bits and saturating stall/issue counters
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_idex_valid <= 1'b0;
            o_idex_is_signed <= 1'b0;
            o_halted <= 1'b0;
            o_stall_count <= '0;
            o_issue_count <= '0;
        end else begin
            o_idex_valid <= do_issue & i_instr_valid;
            if (do_issue) o_idex_is_signed <= o_is_signed;
            if (do_halt) o_halted <= 1'b1;
            if (do_stall && !(&o_stall_count)) o_stall_count <= o_stall_count + 1'b1;
            if (do_issue && i_instr_valid && !(&o_issue_count)) o_issue_count <= o_issue_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_id_issue_controller.sv
// tb_id_issue_controller: directed vectors with a queued scoreboard for id_issue_controller
module tb_id_issue_controller;
    localparam int CW = 4;
    localparam logic [31:0] ORI   = 32'h3421_8000;
    localparam logic [31:0] ADDI  = 32'h2021_8000;
    localparam logic [31:0] LW    = 32'h8C02_0000;
    localparam logic [31:0] ADD   = 32'h0044_1820;
    localparam logic [31:0] ADDI2 = 32'h20A2_0001;
    localparam logic [31:0] ADD0  = 32'h0004_1820;
    localparam logic [31:0] SW    = 32'hACA2_0000;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic i_reset = 1'b1, i_instr_valid = 1'b0, i_idex_mem_read = 1'b0;
    logic i_branch_flush = 1'b0, i_debug_mode = 1'b0, i_step = 1'b0;
    logic [31:0] i_instruction = '0;
    logic [4:0] i_idex_rt = '0;
    logic o_is_signed, o_advance, o_idex_valid, o_idex_is_signed, o_halted;
    logic [CW-1:0] o_stall_count, o_issue_count;

    typedef struct {
        int row;
        bit ck, cr;
        logic sig, adv, v, ss, h;
        logic [CW-1:0] sc, ic;
    } exp_t;
    exp_t q[$];
    exp_t it, prev;
    bit have_prev = 0;
    int errors = 0, checks = 0, row_n = 0;

    id_issue_controller #(.CNT_W(CW)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_instr_valid(i_instr_valid),
        .i_instruction(i_instruction), .i_idex_mem_read(i_idex_mem_read),
        .i_idex_rt(i_idex_rt), .i_branch_flush(i_branch_flush),
        .i_debug_mode(i_debug_mode), .i_step(i_step),
        .o_is_signed(o_is_signed), .o_advance(o_advance), .o_idex_valid(o_idex_valid),
        .o_idex_is_signed(o_idex_is_signed), .o_halted(o_halted),
        .o_stall_count(o_stall_count), .o_issue_count(o_issue_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int row, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL row%0d %s got=%0h exp=%0h", row, nm, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] sat(input int n);
        int m;
        m = (n > (1 << CW) - 1) ? (1 << CW) - 1 : n;
        return m[CW-1:0];
    endfunction

    // Applies one cycle of inputs; comb expectations hold before the edge, reg expectations after it
    task automatic cyc(input logic r, val, input logic [31:0] ins, input logic mr, input logic [4:0] irt,
                       input logic fl, dbg, stp, input bit ck, input logic sig, adv,
                       input bit cr, input logic v, ss, h, input logic [CW-1:0] sc, ic);
        exp_t e;
        i_reset = r; i_instr_valid = val; i_instruction = ins; i_idex_mem_read = mr;
        i_idex_rt = irt; i_branch_flush = fl; i_debug_mode = dbg; i_step = stp;
        e.row = row_n; e.ck = ck; e.cr = cr; e.sig = sig; e.adv = adv;
        e.v = v; e.ss = ss; e.h = h; e.sc = sc; e.ic = ic;
        row_n++;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: each negedge pops one expectation; checks its comb outputs and the previous row's registered results
    always @(negedge clk) begin
        if (q.size() > 0) begin
            it = q.pop_front();
            if (it.ck) begin
                chk("is_signed", it.row, o_is_signed, it.sig);
                chk("advance", it.row, o_advance, it.adv);
            end
            if (have_prev && prev.cr) begin
                chk("idex_valid", prev.row, o_idex_valid, prev.v);
                chk("idex_is_signed", prev.row, o_idex_is_signed, prev.ss);
                chk("halted", prev.row, o_halted, prev.h);
                chk("stall_count", prev.row, o_stall_count, prev.sc);
                chk("issue_count", prev.row, o_issue_count, prev.ic);
            end
            prev = it;
            have_prev = 1;
        end
    end

    initial begin
        @(posedge clk);
        #1;
        //  r val ins   mr irt fl dbg stp | ck sig adv | cr v ss h sc ic
        cyc(1, 0, 0,     0, 0, 0, 0, 0,   0, 0, 0,   1, 0, 0, 0, 0, 0);
        cyc(0, 1, ORI,   0, 0, 0, 0, 0,   1, 0, 1,   1, 1, 0, 0, 0, 1);
        cyc(0, 1, ADDI,  0, 0, 0, 0, 0,   1, 1, 1,   1, 1, 1, 0, 0, 2);
        cyc(0, 1, LW,    0, 0, 0, 0, 0,   1, 1, 1,   1, 1, 1, 0, 0, 3);
        cyc(0, 1, ADD,   1, 2, 0, 0, 0,   1, 1, 0,   1, 0, 1, 0, 1, 3);
        cyc(0, 1, ADD,   1, 2, 0, 0, 0,   1, 1, 1,   1, 1, 1, 0, 1, 4);
        cyc(0, 1, ADDI2, 1, 2, 0, 0, 0,   1, 1, 1,   1, 1, 1, 0, 1, 5);
        cyc(0, 1, ADD0,  1, 0, 0, 0, 0,   1, 1, 1,   1, 1, 1, 0, 1, 6);
        cyc(0, 1, SW,    1, 2, 0, 0, 0,   1, 1, 0,   1, 0, 1, 0, 2, 6);
        cyc(0, 1, SW,    0, 2, 0, 0, 0,   1, 1, 1,   1, 1, 1, 0, 2, 7);
        cyc(0, 1, ORI,   0, 0, 0, 1, 0,   1, 0, 0,   1, 0, 1, 0, 2, 7);
        cyc(0, 1, ORI,   0, 0, 0, 1, 0,   1, 0, 0,   1, 0, 1, 0, 2, 7);
        cyc(0, 1, ORI,   0, 0, 0, 1, 0,   1, 0, 0,   1, 0, 1, 0, 2, 7);
        cyc(0, 1, ORI,   0, 0, 0, 1, 1,   1, 0, 1,   1, 1, 0, 0, 2, 8);
        cyc(0, 1, ADD,   1, 2, 0, 1, 1,   1, 1, 0,   1, 0, 0, 0, 3, 8);
        cyc(0, 1, ADD,   1, 2, 0, 1, 0,   1, 1, 1,   1, 1, 1, 0, 3, 9);
        cyc(0, 1, ORI,   0, 0, 0, 1, 0,   1, 0, 0,   1, 0, 1, 0, 3, 9);
        cyc(0, 1, ORI,   0, 0, 0, 0, 0,   1, 0, 0,   1, 0, 1, 0, 3, 9);
        cyc(0, 0, 0,     0, 0, 0, 0, 0,   1, 1, 1,   1, 0, 1, 0, 3, 9);
        cyc(0, 1, ORI,   0, 0, 0, 0, 0,   1, 0, 1,   1, 1, 0, 0, 3, 10);
        cyc(0, 1, ADD,   1, 2, 1, 0, 0,   1, 1, 1,   1, 0, 0, 0, 3, 10);
        cyc(0, 1, ORI,   0, 0, 1, 1, 0,   1, 0, 1,   1, 0, 0, 0, 3, 10);
        cyc(0, 1, ORI,   0, 0, 0, 1, 0,   1, 0, 0,   1, 0, 0, 0, 3, 10);
        cyc(0, 0, 0,     0, 0, 0, 0, 0,   1, 1, 0,   1, 0, 0, 0, 3, 10);
        cyc(0, 1, HALT,  0, 0, 0, 0, 0,   1, 1, 0,   1, 0, 0, 1, 3, 10);
        cyc(0, 1, ORI,   0, 0, 1, 0, 1,   1, 0, 0,   1, 0, 0, 1, 3, 10);
        cyc(0, 1, ADDI,  0, 0, 0, 1, 1,   1, 1, 0,   1, 0, 0, 1, 3, 10);
        cyc(1, 1, ORI,   0, 0, 0, 0, 0,   1, 0, 0,   1, 0, 0, 0, 0, 0);
        cyc(0, 1, ADDI,  0, 0, 0, 0, 0,   1, 1, 1,   1, 1, 1, 0, 0, 1);
        cyc(0, 1, ADD,   1, 2, 0, 0, 0,   1, 1, 0,   1, 0, 1, 0, 1, 1);
        cyc(1, 1, ADD,   1, 2, 0, 0, 0,   1, 1, 1,   1, 0, 0, 0, 0, 0);
        cyc(0, 1, ADD,   1, 2, 0, 0, 0,   1, 1, 1,   1, 1, 1, 0, 0, 1);
        for (int k = 1; k <= (1 << CW) + 3; k++) begin
            cyc(0, 1, ADD, 1, 2, 0, 0, 0,   1, 1, 0,   1, 0, 1, 0, sat(k), sat(k));
            cyc(0, 1, ADD, 1, 2, 0, 0, 0,   1, 1, 1,   1, 1, 1, 0, sat(k), sat(k + 1));
        end
        cyc(0, 0, 0,     0, 0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain queue_left=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
